// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl -- parametrised GPIO controller, single-cycle-grant bus slave.
//
// Per-pin output data and direction, synchronised inputs, atomic
// set/clear/toggle writes, and rising/falling edge interrupts with a
// write-1-to-clear status register.
//
// Optional feature macro: GPIO_DEBOUNCE_EN
//   Defined   : DEBOUNCE (0x24) is an RW 8-bit register. A non-zero value N
//               makes each pin's synchronised input wait for N consecutive
//               differing cycles before the debounced value follows it.
//   Undefined : DEBOUNCE reads 0, writes are ignored, no counters exist.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   req_i, we_i        bus request, 1=write / 0=read
//   be_i, addr_i       byte enables, byte address (bits [1:0] ignored)
//   wdata_i            write data
//   gnt_o              grant (combinational copy of req_i)
//   rvalid_o, rdata_o  response one cycle after each grant; rdata 0 for writes
//   gpio_i             asynchronous pad inputs
//   gpio_o, gpio_oe_o  pad outputs and output enables (1 = drive)
//   irq_o              registered level interrupt, OR of IRQ_STATUS
// -----------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int unsigned      NGPIO       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [NGPIO-1:0] OUT_RST     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe_o,
  output logic             irq_o
);

  // Word indices (addr_i[7:2]) of the register map.
  localparam logic [5:0] ADDR_DATA_OUT = 6'h00;
  localparam logic [5:0] ADDR_SET      = 6'h01;
  localparam logic [5:0] ADDR_CLR      = 6'h02;
  localparam logic [5:0] ADDR_TGL      = 6'h03;
  localparam logic [5:0] ADDR_DIR      = 6'h04;
  localparam logic [5:0] ADDR_DATA_IN  = 6'h05;
  localparam logic [5:0] ADDR_RISE_EN  = 6'h06;
  localparam logic [5:0] ADDR_FALL_EN  = 6'h07;
  localparam logic [5:0] ADDR_STATUS   = 6'h08;
  localparam logic [5:0] ADDR_DEBOUNCE = 6'h09;

  logic [NGPIO-1:0] out_q, out_d;
  logic [NGPIO-1:0] dir_q, dir_d;
  logic [NGPIO-1:0] rise_en_q, rise_en_d;
  logic [NGPIO-1:0] fall_en_q, fall_en_d;
  logic [NGPIO-1:0] status_q, status_d;
  logic [NGPIO-1:0] prev_q;
  logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q;
  logic             irq_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en, rd_en;
  logic [31:0]      byte_mask;
  logic [NGPIO-1:0] wmask, wbits;
  logic [NGPIO-1:0] sync_in, filt_in, rise, fall, edge_hit;
  logic [7:0]       deb_rd;

  // Address low bits and write data above NGPIO are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i};

  assign wr_en     = req_i & we_i;
  assign rd_en     = req_i & ~we_i;
  assign byte_mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign wmask     = byte_mask[NGPIO-1:0];
  // Bits the write actually carries as '1' within enabled bytes.
  assign wbits     = wdata_i[NGPIO-1:0] & wmask;

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0]            deb_q, deb_d;
  logic [NGPIO-1:0]      db_q, db_d;
  logic [NGPIO-1:0][7:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    db_d  = db_q;
    cnt_d = '0;
    if (wr_en && (addr_i[7:2] == ADDR_DEBOUNCE) && be_i[0]) begin
      deb_d = wdata_i[7:0];
    end
    for (int i = 0; i < int'(NGPIO); i++) begin
      if (deb_q == 8'd0) begin
        // Bypass: track sync_in so enabling debounce starts from the live value.
        db_d[i] = sync_in[i];
      end else if (sync_in[i] != db_q[i]) begin
        // '>=' also covers N being lowered while a count is in flight.
        if (cnt_q[i] + 8'd1 >= deb_q) begin
          db_d[i] = sync_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      deb_q <= '0;
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign filt_in = (deb_q == 8'd0) ? sync_in : db_q;
  assign deb_rd  = deb_q;
`else
  assign filt_in = sync_in;
  assign deb_rd  = '0;
`endif

  assign rise     = filt_in & ~prev_q;
  assign fall     = ~filt_in & prev_q;
  assign edge_hit = (rise & rise_en_q) | (fall & fall_en_q);

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q | edge_hit;
    rdata_d   = '0;

    if (wr_en) begin
      case (addr_i[7:2])
        ADDR_DATA_OUT: out_d     = (out_q & ~wmask) | wbits;
        ADDR_SET:      out_d     = out_q | wbits;
        ADDR_CLR:      out_d     = out_q & ~wbits;
        ADDR_TGL:      out_d     = out_q ^ wbits;
        ADDR_DIR:      dir_d     = (dir_q & ~wmask) | wbits;
        ADDR_RISE_EN:  rise_en_d = (rise_en_q & ~wmask) | wbits;
        ADDR_FALL_EN:  fall_en_d = (fall_en_q & ~wmask) | wbits;
        // A new edge in the same cycle as its clear keeps the bit set.
        ADDR_STATUS:   status_d  = (status_q & ~wbits) | edge_hit;
        default: ;
      endcase
    end

    if (rd_en) begin
      case (addr_i[7:2])
        ADDR_DATA_OUT: rdata_d = 32'(out_q);
        ADDR_DIR:      rdata_d = 32'(dir_q);
        ADDR_DATA_IN:  rdata_d = 32'(filt_in);
        ADDR_RISE_EN:  rdata_d = 32'(rise_en_q);
        ADDR_FALL_EN:  rdata_d = 32'(fall_en_q);
        ADDR_STATUS:   rdata_d = 32'(status_q);
        ADDR_DEBOUNCE: rdata_d = 32'(deb_rd);
        default:       rdata_d = '0;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q     <= OUT_RST;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      // NOTE: the synchroniser chain is reset as well, so edge detection
      // starts from a known all-zero history rather than X.
      sync_q    <= '0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= filt_in;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      irq_q     <= |status_q;
      rvalid_q  <= req_i;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl -- directed self-checking bench for gpio_ctrl
// (NGPIO=32, SYNC_STAGES=2, OUT_RST=0x8000_0003).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpio_ctrl;

  localparam int unsigned NGPIO       = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [31:0] OUT_RST     = 32'h8000_0003;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [7:0]  addr_i = 8'h00;
  logic [31:0] wdata_i = 32'h0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [31:0] gpio_i = 32'h0;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] b2b_exp [8] = '{32'h0000_FF00, 32'h0, 32'h0, 32'h0,
                               32'hFFFF_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};

  gpio_ctrl #(
    .NGPIO      (NGPIO),
    .SYNC_STAGES(SYNC_STAGES),
    .OUT_RST    (OUT_RST)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe_o(gpio_oe_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    #1 check("wr_gnt", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check("wr_rvalid", 32'(rvalid_o), 32'd1);
    check("wr_rdata", rdata_o, 32'd0);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    check({tag, "_idle"}, 32'(rvalid_o), 32'd0);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    check(tag, rdata_o, exp);
  endtask

  initial begin
    // ---- reset and register defaults ----
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("rst_gpio_o", gpio_o, OUT_RST);
    check("rst_oe", gpio_oe_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    bus_read(8'h00, OUT_RST, "rd_data_out");
    bus_read(8'h04, 32'h0, "rd_set");
    bus_read(8'h08, 32'h0, "rd_clr");
    bus_read(8'h0C, 32'h0, "rd_tgl");
    bus_read(8'h10, 32'h0, "rd_dir");
    bus_read(8'h14, 32'h0, "rd_data_in");
    bus_read(8'h18, 32'h0, "rd_rise_en");
    bus_read(8'h1C, 32'h0, "rd_fall_en");
    bus_read(8'h20, 32'h0, "rd_status");
    bus_read(8'h24, 32'h0, "rd_debounce");
    bus_read(8'h28, 32'h0, "rd_unmapped");

    // ---- output data: write / set / clear / toggle / byte enables ----
    bus_write(8'h00, 32'h0000_00F0, 4'hF);
    check("out_write", gpio_o, 32'h0000_00F0);
    bus_write(8'h04, 32'h0000_000F, 4'hF);
    check("out_set", gpio_o, 32'h0000_00FF);
    bus_write(8'h08, 32'h0000_0030, 4'hF);
    check("out_clr", gpio_o, 32'h0000_00CF);
    bus_write(8'h0C, 32'h0000_0101, 4'hF);
    check("out_tgl", gpio_o, 32'h0000_01CE);
    bus_read(8'h00, 32'h0000_01CE, "rd_out_1ce");
    bus_write(8'h00, 32'hFFFF_FF00, 4'b0001);
    check("out_be0", gpio_o, 32'h0000_0100);
    bus_write(8'h04, 32'hFFFF_FFFF, 4'b0010);
    check("set_be1", gpio_o, 32'h0000_FF00);
    bus_write(8'h08, 32'hFFFF_FFFF, 4'b0000);
    check("clr_be_none", gpio_o, 32'h0000_FF00);
    bus_write(8'h40, 32'hFFFF_FFFF, 4'hF);
    check("unmapped_wr", gpio_o, 32'h0000_FF00);
    bus_read(8'h04, 32'h0, "rd_set_wo");

    // ---- direction and synchronised inputs ----
    bus_write(8'h10, 32'hFFFF_0000, 4'hF);
    check("dir_oe", gpio_oe_o, 32'hFFFF_0000);
    check("dir_gpio_o", gpio_o, 32'h0000_FF00);
    bus_read(8'h10, 32'hFFFF_0000, "rd_dir_set");
    @(negedge clk_i);
    gpio_i = 32'h0000_A5A5;
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h14;
    @(negedge clk_i);
    check("din_lat0", rdata_o, 32'h0);
    @(negedge clk_i);
    check("din_lat1", rdata_o, 32'h0);
    @(negedge clk_i);
    check("din_lat2", rdata_o, 32'h0000_A5A5);
    req_i = 1'b0;

    // ---- edge interrupts ----
    @(negedge clk_i);
    gpio_i = 32'h0000_0002;
    repeat (4) @(negedge clk_i);
    bus_write(8'h18, 32'h0000_0001, 4'hF);
    bus_write(8'h1C, 32'h0000_0002, 4'hF);
    bus_read(8'h20, 32'h0, "sts_no_retro");
    @(negedge clk_i);
    gpio_i = 32'h0000_0001;       // rise on pin 0, fall on pin 1
    @(negedge clk_i);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h20;
    @(negedge clk_i);
    check("sts_early", rdata_o, 32'h0);
    check("irq_early", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    check("sts_set", rdata_o, 32'h0000_0003);
    check("irq_set", 32'(irq_o), 32'd1);
    req_i = 1'b0;
    bus_write(8'h20, 32'h0000_0001, 4'hF);
    bus_read(8'h20, 32'h0000_0002, "sts_w1c0");
    check("irq_still", 32'(irq_o), 32'd1);
    @(negedge clk_i);
    gpio_i = 32'h0000_0003;       // pin 1 rises, not enabled
    repeat (4) @(negedge clk_i);
    gpio_i = 32'h0000_0001;       // pin 1 falls; its flag lands with the clear
    @(negedge clk_i);
    bus_write(8'h20, 32'h0000_0002, 4'hF);
    bus_read(8'h20, 32'h0000_0002, "sts_set_wins");
    bus_write(8'h20, 32'h0000_0002, 4'hF);
    check("irq_lag", 32'(irq_o), 32'd1);
    @(negedge clk_i);
    check("irq_clear", 32'(irq_o), 32'd0);
    bus_read(8'h20, 32'h0, "sts_cleared");

    // ---- debounce ----
`ifdef GPIO_DEBOUNCE_EN
    bus_write(8'h18, 32'h0000_0005, 4'hF);
    bus_write(8'h24, 32'h0000_0004, 4'hF);
    bus_read(8'h24, 32'h0000_0004, "deb_rd");
    @(negedge clk_i);
    gpio_i = 32'h0000_0005;       // 3-cycle glitch on pin 2
    repeat (3) @(negedge clk_i);
    gpio_i = 32'h0000_0001;
    repeat (6) @(negedge clk_i);
    bus_read(8'h14, 32'h0000_0001, "deb_glitch_in");
    bus_read(8'h20, 32'h0, "deb_glitch_sts");
    check("deb_glitch_irq", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    gpio_i = 32'h0000_0005;       // stable change on pin 2
    repeat (5) @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h14;
    @(negedge clk_i);
    check("deb_before", rdata_o, 32'h0000_0001);
    @(negedge clk_i);
    check("deb_after", rdata_o, 32'h0000_0005);
    req_i = 1'b0;
    bus_read(8'h20, 32'h0000_0004, "deb_sts");
    bus_write(8'h24, 32'h0, 4'hF);
    bus_write(8'h18, 32'h0000_0001, 4'hF);
    @(negedge clk_i);
    gpio_i = 32'h0000_0001;
    repeat (4) @(negedge clk_i);
    bus_write(8'h20, 32'hFFFF_FFFF, 4'hF);
`else
    bus_write(8'h24, 32'h0000_00FF, 4'hF);
    bus_read(8'h24, 32'h0, "deb_absent");
`endif

    // ---- back-to-back reads, then reset mid-stream ----
    @(negedge clk_i);
    check("b2b_idle", 32'(rvalid_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = 8'(i * 4);
      @(negedge clk_i);
      check("b2b_rvalid", 32'(rvalid_o), 32'd1);
      check("b2b_rdata", rdata_o, b2b_exp[i]);
    end
    addr_i = 8'h00;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("mid_rst_rdata", rdata_o, 32'd0);
    check("mid_rst_gpio_o", gpio_o, OUT_RST);
    check("mid_rst_oe", gpio_oe_o, 32'd0);
    rst_ni = 1'b1;
    req_i = 1'b0;
    bus_read(8'h00, OUT_RST, "post_rst_out");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised GPIO controller for the top_core peripheral bus. It is the successor to the fixed 32-bit write-only gpio_o port. Adds:
- configurable pin count
- per-pin direction
- synchronised inputs
- atomic set/clear/toggle writes
- rising/falling edge interrupts

It sits behind the core's data bus as a single-cycle-grant slave. It drives gpio_o / gpio_oe_o to the pads and irq_o to the core.

Parameters:
NGPIO, 32, number of pins, 1..32; register bits above NGPIO-1 read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth, 2..4
OUT_RST, 0, reset value of DATA_OUT, NGPIO bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
req_i  in  1  bus request
we_i  in  1  1=write, 0=read
be_i  in  4  byte enables for writes
addr_i  in  8  byte address; bits [1:0] ignored
wdata_i  in  32  write data
gnt_o  out  1  grant
rvalid_o  out  1  response valid
rdata_o  out  32  read data
gpio_i  in  NGPIO  pad inputs (asynchronous)
gpio_o  out  NGPIO  pad outputs
gpio_oe_o  out  NGPIO  output enables, 1=drive
irq_o  out  1  level interrupt

Behaviour:
- Reset: synchronous, active-low, one clk_i edge with rst_ni=0 clears everything.
  - After reset: gpio_o=OUT_RST, gpio_oe_o=0, irq_o=0, rvalid_o=0, rdata_o=0.
  - Synchroniser, previous-sample and all other registers are 0.
  - A reset mid-transaction drops any pending rvalid.
- Bus handshake:
  - gnt_o = req_i (combinational, never stalls).
  - Each granted request produces rvalid_o=1 exactly one cycle later, for writes and reads alike.
  - rdata_o is valid only while rvalid_o=1. It is 0 on write responses and on unmapped addresses.
  - Back-to-back requests are supported every cycle.
- Register map (byte offsets):
  - 0x00 DATA_OUT, RW
  - 0x04 SET, WO: write-1 sets DATA_OUT bits
  - 0x08 CLR, WO: write-1 clears DATA_OUT bits
  - 0x0C TGL, WO: write-1 inverts DATA_OUT bits
  - 0x10 DIR, RW: 1 = output
  - 0x14 DATA_IN, RO: synchronised inputs
  - 0x18 IRQ_RISE_EN, RW
  - 0x1C IRQ_FALL_EN, RW
  - 0x20 IRQ_STATUS, RW1C
  - 0x24 DEBOUNCE, see Optional Feature
  - WO registers read 0. Unmapped addresses: writes ignored, reads return 0.
- Byte enables gate every write per byte. For SET/CLR/TGL, a disabled byte means no change.
- Write timing: a write takes effect on the grant-cycle edge, so gpio_o / gpio_oe_o change 1 cycle after req_i&we_i.
- Output mapping: gpio_o = DATA_OUT. gpio_oe_o = DIR. gpio_o is driven regardless of DIR.
- Input path: gpio_i passes through SYNC_STAGES flops to give sync_in, plus one prev flop.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - DATA_IN = sync_in, so a pad change is visible SYNC_STAGES cycles later.
- IRQ_STATUS[n] sets when (rise[n] & IRQ_RISE_EN[n]) | (fall[n] & IRQ_FALL_EN[n]).
  - Edge to status latency: SYNC_STAGES+1 cycles.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
  - Edges on pins with DIR=1 are still detected.
- irq_o is registered: irq_o = |(IRQ_STATUS) on the next cycle. It deasserts one cycle after the last status bit clears.
- Enabling an IRQ does not retro-flag edges that occurred before enable.

Optional Feature:
Macro GPIO_DEBOUNCE_EN.
- Defined:
  - DEBOUNCE is an RW 8-bit register, reset 0.
  - When DEBOUNCE=N>0, each pin has an 8-bit counter.
  - sync_in must differ from the debounced value for N consecutive cycles before the debounced value updates. The counter resets on any mismatch gap.
  - DATA_IN and edge detection use the debounced value.
  - N=0 bypasses debounce (identical to undefined behaviour).
- Undefined: DEBOUNCE reads 0, writes ignored, no counters synthesised.

Test Plan:
- Reset then read every register -> DATA_OUT=OUT_RST, all others 0; gpio_oe_o=0; irq_o=0; each read's rvalid_o arrives exactly 1 cycle after req_i.
- Write DATA_OUT=0x0000_00F0, SET=0x0F, CLR=0x30, TGL=0x101 -> gpio_o=0x0000_01CE; read DATA_OUT=0x1CE; a write with be_i=0001 and data 0xFFFF_FF00 to DATA_OUT -> gpio_o=0x0000_0100.
- DIR=0xFFFF_0000, gpio_i=0x0000_A5A5 -> gpio_oe_o=0xFFFF0000; DATA_IN reads 0xA5A5 starting SYNC_STAGES cycles after the pad change, 0 before.
- IRQ_RISE_EN=0x1, IRQ_FALL_EN=0x2; raise gpio_i[0], lower gpio_i[1] -> IRQ_STATUS=0x3 after SYNC_STAGES+1 cycles; irq_o=1 one cycle later; W1C 0x1 -> status 0x2; W1C 0x2 coincident with a new fall on pin 1 -> status stays 0x2.
- Back-to-back: 8 consecutive reads with req_i held high -> 8 rvalid_o pulses on consecutive cycles with the correct data in order; assert rst_ni=0 mid-stream -> rvalid_o=0 on the next cycle.
- With GPIO_DEBOUNCE_EN, DEBOUNCE=4: a 3-cycle glitch on gpio_i[2] -> no DATA_IN change and no IRQ; a 4-cycle-stable change -> DATA_IN[2] updates after SYNC_STAGES+4 cycles.
